hint_anim_ctrl: RTL and testbench

//  Upstream controller for one hint sprite stage (177x26 text banner).

---
 rtl/hint_anim_pkg.sv | 15 +
 rtl/frame_tick_gen.sv | 24 ++
 rtl/hint_anim_ctrl.sv | 159 +++++++++++++++
 tb/tb_hint_anim_ctrl.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/hint_anim_pkg.sv
// Shared state encoding and screen geometry for the hint banner animation.
package hint_anim_pkg;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SLIDE_IN  = 3'd1,
    ST_BLINK     = 3'd2,
    ST_HOLD      = 3'd3,
    ST_SLIDE_OUT = 3'd4
  } anim_state_t;

endpackage

// File: rtl/frame_tick_gen.sv
// One-cycle pulse on the first cycle the scan reaches (0, TICK_Y); reusable
// by any stage that must only move during vertical blanking.
module frame_tick_gen #(
  parameter int TICK_Y = 480
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] x,
  input  logic [8:0] y,
  output logic       tick
);

  logic raw;
  logic raw_q;

  assign raw  = (y == 9'(TICK_Y)) && (x == 10'd0);
  assign tick = raw & ~raw_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) raw_q <= 1'b0;
    else     raw_q <= raw;
  end

endmodule

// File: rtl/hint_anim_ctrl.sv
// Hint banner controller: slide in, blink, hold, slide out; all position
// and visibility changes happen on the blanking frame tick.
module hint_anim_ctrl
  import hint_anim_pkg::*;
#(
  parameter int TARGET_X      = (SCREEN_W - 177) / 2,
  parameter int TARGET_Y      = 227,
  parameter int START_Y       = 480,
  parameter int SLIDE_STEP    = 8,
  parameter int BLINK_FRAMES  = 15,
  parameter int BLINK_TOGGLES = 6,
  parameter int HOLD_FRAMES   = 120,
  parameter int TICK_Y        = SCREEN_H
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] x,
  input  logic [8:0] y,
  input  logic       trigger,
  input  logic       dismiss,
  output logic [9:0] posx,
  output logic [8:0] posy,
  output logic       isplay,
  output logic       busy
);

  localparam logic [8:0] TY    = 9'(TARGET_Y);
  localparam logic [8:0] SY    = 9'(START_Y);
  localparam logic [8:0] STEP  = 9'(SLIDE_STEP);
  localparam logic [7:0] BLAST = 8'(BLINK_FRAMES - 1);
  localparam logic [7:0] HLAST = 8'(HOLD_FRAMES - 1);
  localparam logic [3:0] TOGS  = 4'(BLINK_TOGGLES);

  anim_state_t state_reg, state_next;
  logic [8:0]  posy_reg, posy_next;
  logic        isplay_reg, isplay_next;
  logic [7:0]  cnt_reg, cnt_next;
  logic [3:0]  tog_reg, tog_next;
  logic        trig_reg, trig_next;
  logic        dism_reg, dism_next;
  logic        tick;
  logic        trig_eff, dism_eff;
  logic [3:0]  tog_inc;

  frame_tick_gen #(.TICK_Y(TICK_Y)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .x    (x),
    .y    (y),
    .tick (tick)
  );

  // A request arriving on the tick cycle itself is honoured on that tick.
  assign trig_eff = trig_reg | trigger;
  assign dism_eff = dism_reg | dismiss;
  assign tog_inc  = tog_reg + 4'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= ST_IDLE;
      posy_reg   <= SY;
      isplay_reg <= 1'b0;
      cnt_reg    <= 8'd0;
      tog_reg    <= 4'd0;
      trig_reg   <= 1'b0;
      dism_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      posy_reg   <= posy_next;
      isplay_reg <= isplay_next;
      cnt_reg    <= cnt_next;
      tog_reg    <= tog_next;
      trig_reg   <= trig_next;
      dism_reg   <= dism_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    posy_next   = posy_reg;
    isplay_next = isplay_reg;
    cnt_next    = cnt_reg;
    tog_next    = tog_reg;
    trig_next   = trig_eff;
    dism_next   = dism_eff;
    if (tick) begin
      trig_next = 1'b0;
      dism_next = 1'b0;
      case (state_reg)
        ST_IDLE: begin
          isplay_next = 1'b0;
          posy_next   = SY;
          if (trig_eff) begin
            state_next = ST_SLIDE_IN;
            cnt_next   = 8'd0;
            tog_next   = 4'd0;
          end
        end
        ST_SLIDE_IN: begin
          isplay_next = 1'b1;
          if (dism_eff) begin
            state_next = ST_SLIDE_OUT;
          end else if (posy_reg - TY <= STEP) begin
            posy_next  = TY;
            cnt_next   = 8'd0;
            tog_next   = 4'd0;
            state_next = ST_BLINK;
          end else begin
            posy_next = posy_reg - STEP;
          end
        end
        ST_BLINK: begin
          if (dism_eff) begin
            isplay_next = 1'b1;
            state_next  = ST_SLIDE_OUT;
          end else if (cnt_reg == BLAST) begin
            cnt_next = 8'd0;
            if (tog_inc == TOGS) begin
              tog_next    = 4'd0;
              isplay_next = 1'b1;
              state_next  = ST_HOLD;
            end else begin
              tog_next    = tog_inc;
              isplay_next = ~isplay_reg;
            end
          end else begin
            cnt_next = cnt_reg + 8'd1;
          end
        end
        ST_HOLD: begin
          isplay_next = 1'b1;
          cnt_next    = cnt_reg + 8'd1;
          if (dism_eff || (HOLD_FRAMES != 0 && cnt_reg == HLAST)) begin
            state_next = ST_SLIDE_OUT;
          end
        end
        ST_SLIDE_OUT: begin
          isplay_next = 1'b1;
          if (trig_eff) begin
            state_next = ST_SLIDE_IN;
          end else if (SY - posy_reg <= STEP) begin
            posy_next   = SY;
            isplay_next = 1'b0;
            state_next  = ST_IDLE;
          end else begin
            posy_next = posy_reg + STEP;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  assign posx   = 10'(TARGET_X);
  assign posy   = posy_reg;
  assign isplay = isplay_reg;
  assign busy   = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_hint_anim_ctrl.sv
// Frame-level bench for hint_anim_ctrl: short synthetic frames, random scan
// filler and requests, compared against a phase/position reference model.
module tb_hint_anim_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] x = 10'd1;
  logic [8:0] y = 9'd0;
  logic       trigger = 1'b0;
  logic       dismiss = 1'b0;
  logic [9:0] posx;
  logic [8:0] posy;
  logic       isplay;
  logic       busy;

  hint_anim_ctrl dut (
    .clk(clk), .rst(rst), .x(x), .y(y), .trigger(trigger), .dismiss(dismiss),
    .posx(posx), .posy(posy), .isplay(isplay), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int ticks = 0;

  always @(negedge clk) if (dut.tick) ticks++;

  // Reference model: banner phase, top edge, visibility, ticks spent in phase.
  typedef enum {M_OFF, M_UP, M_FLASH, M_REST, M_DOWN} mph_t;
  mph_t m_ph;
  int   m_y;
  int   m_n;
  bit   m_vis;

  function automatic void model_reset();
    m_ph = M_OFF; m_y = 480; m_n = 0; m_vis = 1'b0;
  endfunction

  function automatic void model_step(bit tr, bit di);
    case (m_ph)
      M_OFF: begin
        m_vis = 1'b0;
        if (tr) m_ph = M_UP;
      end
      M_UP: begin
        m_vis = 1'b1;
        if (di) m_ph = M_DOWN;
        else if (m_y - 8 <= 227) begin m_y = 227; m_n = 0; m_ph = M_FLASH; end
        else m_y = m_y - 8;
      end
      M_FLASH: begin
        if (di) begin m_vis = 1'b1; m_ph = M_DOWN; end
        else begin
          m_n++;
          m_vis = ((m_n / 15) % 2) == 0;
          if (m_n == 90) begin m_n = 0; m_vis = 1'b1; m_ph = M_REST; end
        end
      end
      M_REST: begin
        m_vis = 1'b1;
        m_n++;
        if (di || m_n == 120) m_ph = M_DOWN;
      end
      M_DOWN: begin
        m_vis = 1'b1;
        if (tr) m_ph = M_UP;
        else if (m_y + 8 >= 480) begin m_y = 480; m_vis = 1'b0; m_ph = M_OFF; end
        else m_y = m_y + 8;
      end
      default: m_ph = M_OFF;
    endcase
  endfunction

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic cyc(input int xv, input int yv, input bit tr, input bit di);
    @(posedge clk); #1;
    x = 10'(xv); y = 9'(yv); trigger = tr; dismiss = di;
  endtask

  task automatic scan_cyc(input bit tr, input bit di);
    int xv = $urandom_range(0, 799);
    int yv = $urandom_range(0, 511);
    if (yv == 480 && xv == 0) xv = 1;
    cyc(xv, yv, tr, di);
  endtask

  task automatic frame(input bit tr, input bit di, input string tag);
    int npre = $urandom_range(2, 5);
    int tp = $urandom_range(0, npre - 1);
    int dp = $urandom_range(0, npre - 1);
    int hold = $urandom_range(1, 3);
    int t0 = ticks;
    for (int i = 0; i < npre; i++) scan_cyc(tr && i == tp, di && i == dp);
    for (int i = 0; i < hold; i++) cyc(0, 480, 1'b0, 1'b0);
    scan_cyc(1'b0, 1'b0);
    @(negedge clk);
    model_step(tr, di);
    chk({tag, ".ticks"}, ticks - t0, 1);
    chk({tag, ".posy"}, int'(posy), m_y);
    chk({tag, ".isplay"}, int'(isplay), int'(m_vis));
    chk({tag, ".busy"}, int'(busy), int'(m_ph != M_OFF));
    chk({tag, ".posx"}, int'(posx), 231);
    $display("frame %s tr=%0b di=%0b posy=%0d isplay=%0b busy=%0b", tag, tr, di, posy, isplay, busy);
  endtask

  task automatic async_reset(input string tag);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk({tag, ".posy"}, int'(posy), 480);
    chk({tag, ".isplay"}, int'(isplay), 0);
    chk({tag, ".busy"}, int'(busy), 0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    int cnt;
    model_reset();
    repeat (3) cyc(5, 10, 1'b0, 1'b0);
    @(negedge clk);
    chk("reset.posy", int'(posy), 480);
    chk("reset.isplay", int'(isplay), 0);
    chk("reset.busy", int'(busy), 0);
    chk("reset.posx", int'(posx), 231);
    rst = 1'b0;

    repeat (3) frame(1'b0, 1'b0, "idle");

    // Full show cycle.
    frame(1'b1, 1'b0, "trig");
    frame(1'b0, 1'b0, "in1");
    chk("in1.first_step", int'(posy), 472);
    cnt = 1;
    while (posy != 9'd227 && cnt < 60) begin frame(1'b0, 1'b0, "in"); cnt++; end
    chk("slide_in_len", cnt, 32);
    for (int i = 1; i <= 90; i++) begin
      frame(1'b0, 1'b0, "blink");
      if (i == 15) chk("blink.first_toggle", int'(isplay), 0);
      if (i == 30) chk("blink.second_toggle", int'(isplay), 1);
    end
    chk("hold.entry_isplay", int'(isplay), 1);
    repeat (120) frame(1'b0, 1'b0, "hold");
    frame(1'b0, 1'b0, "out1");
    chk("out1.first_step", int'(posy), 235);
    cnt = 1;
    while (busy && cnt < 60) begin frame(1'b0, 1'b0, "out"); cnt++; end
    chk("slide_out_len", cnt, 32);
    chk("out.final_isplay", int'(isplay), 0);

    // Reversals mid-slide.
    frame(1'b1, 1'b0, "trig2");
    cnt = 0;
    while (m_y != 400 && cnt < 40) begin frame(1'b0, 1'b0, "in2"); cnt++; end
    frame(1'b0, 1'b1, "dism400");
    chk("dism400.posy_held", int'(posy), 400);
    frame(1'b0, 1'b0, "after_dism");
    chk("after_dism.posy", int'(posy), 408);
    cnt = 0;
    while (m_y != 440 && cnt < 40) begin frame(1'b0, 1'b0, "out2"); cnt++; end
    frame(1'b1, 1'b0, "trig440");
    frame(1'b0, 1'b0, "after_trig");
    chk("after_trig.posy", int'(posy), 432);

    // Reset while blinking, then simultaneous requests in IDLE.
    cnt = 0;
    while (m_ph != M_FLASH && cnt < 60) begin frame(1'b0, 1'b0, "to_blink"); cnt++; end
    repeat (20) frame(1'b0, 1'b0, "blink2");
    async_reset("rst_blink");
    frame(1'b1, 1'b1, "both");
    chk("both.busy", int'(busy), 1);
    frame(1'b0, 1'b0, "both_next");
    chk("both_next.posy", int'(posy), 472);

    // Random requests.
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 299) == 0) async_reset("rnd_rst");
      frame($urandom_range(0, 29) == 0, $urandom_range(0, 39) == 0, "rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
